// File: rtl/grant_decoder.sv
// Turns a winning request index into a one-hot grant that is held until the
// owner signals done or a cycle budget expires, followed by one idle gap cycle.
module grant_decoder #(
  parameter int IDXW    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [IDXW-1:0]        in_idx,
  output logic                   in_ready,
  input  logic [(1<<IDXW)-1:0]   done,
  output logic [(1<<IDXW)-1:0]   grant,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [7:0]             grant_count
);

  localparam int N = 1 << IDXW;
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [IDXW-1:0] idx, idx_nxt;
  logic [7:0]      cnt, cnt_nxt;
  logic [7:0]      gcount_nxt;
  logic            terr_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      grant_count <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      cnt         <= cnt_nxt;
      grant_count <= gcount_nxt;
      timeout_err <= terr_nxt;
    end
  end

  // Only done[idx] can end a grant; everything else is don't-care while granting.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    cnt_nxt    = cnt;
    gcount_nxt = grant_count;
    terr_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          idx_nxt   = in_idx;
          cnt_nxt   = 8'd1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (done[idx]) begin
          state_nxt  = GAP;
          cnt_nxt    = '0;
          gcount_nxt = grant_count + 8'd1;
        end else if (cnt >= TO_LIMIT) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
          terr_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      GAP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Grant is decoded from the state register, so reset clears it immediately.
  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state != IDLE);
    grant    = '0;
    if (state == GRANT) grant = {{(N-1){1'b0}}, 1'b1} << idx;
  end

endmodule

// File: tb/tb_grant_decoder.sv
// Self-checking bench for grant_decoder: a vector table, directed corner
// sequences and random traffic against a cycle-level behavioural model.
module tb_grant_decoder;

  localparam int IDXW    = 2;
  localparam int N       = 4;
  localparam int TIMEOUT = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic [IDXW-1:0] in_idx;
  logic            in_ready;
  logic [N-1:0]    done;
  logic [N-1:0]    grant;
  logic            busy;
  logic            timeout_err;
  logic [7:0]      grant_count;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model: who owns the grant (-1 = nobody), for how many cycles, whether we
  // are in the post-grant gap, the pending timeout flag and the done tally.
  int m_owner = -1;
  int m_age   = 0;
  bit m_gap   = 1'b0;
  bit m_terr  = 1'b0;
  int m_count = 0;

  typedef struct {
    logic        v;
    logic [1:0]  idx;
    logic [3:0]  d;
    logic [3:0]  eg;
    logic        er;
    logic        et;
    logic [7:0]  ec;
    string       name;
  } vec_t;

  vec_t tbl[13];

  grant_decoder #(.IDXW(IDXW), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_idx      (in_idx),
    .in_ready    (in_ready),
    .done        (done),
    .grant       (grant),
    .busy        (busy),
    .timeout_err (timeout_err),
    .grant_count (grant_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [3:0] owner_mask();
    if (m_owner < 0) return 4'b0000;
    return 4'(1 << m_owner);
  endfunction

  function automatic bit model_idle();
    return (m_owner < 0) && !m_gap;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_age = 0; m_gap = 1'b0; m_terr = 1'b0; m_count = 0;
  endtask

  task automatic model_edge();
    m_terr = 1'b0;
    if (m_gap) begin
      m_gap = 1'b0;
    end else if (m_owner < 0) begin
      if (in_valid) begin
        m_owner = int'(in_idx);
        m_age   = 1;
      end
    end else if (done[m_owner]) begin
      m_count = (m_count + 1) % 256;
      m_owner = -1;
      m_gap   = 1'b1;
    end else if (m_age == TIMEOUT) begin
      m_owner = -1;
      m_gap   = 1'b1;
      m_terr  = 1'b1;
    end else begin
      m_age++;
    end
  endtask

  task automatic checkOutput(string name, logic [3:0] eg, logic er, logic eb,
                             logic et, logic [7:0] ec);
    checks++;
    if (grant !== eg || in_ready !== er || busy !== eb || timeout_err !== et ||
        grant_count !== ec) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got grant=%b ready=%b busy=%b terr=%b count=%0d, expected grant=%b ready=%b busy=%b terr=%b count=%0d",
               name, cyc, grant, in_ready, busy, timeout_err, grant_count,
               eg, er, eb, et, ec);
    end
    checks++;
    if ($countones(grant) > 1) begin
      errors++;
      $display("[TB] FAIL %s_onehot cycle %0d: got grant=%b, expected at most one bit set",
               name, cyc, grant);
    end
  endtask

  task automatic checkModel(string name);
    checkOutput(name, owner_mask(), model_idle(), !model_idle(), m_terr, 8'(m_count));
  endtask

  task automatic checkValue(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Inputs change at the falling edge; the model advances with the rising edge.
  task automatic applyStimulus(logic v, logic [1:0] i, logic [3:0] d);
    in_valid = v;
    in_idx   = i;
    done     = d;
    model_edge();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(string name);
    for (int k = 0; k < 40 && !model_idle(); k++) begin
      applyStimulus(1'b0, 2'd0, owner_mask());
      checkModel(name);
    end
    checkValue({name, "_idle"}, int'(in_ready), 1);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    model_reset();
    checkOutput("reset_async", 4'b0000, 1'b1, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkModel("reset_release");
  endtask

  initial begin
    int glen, tpulses, base, n_acc;
    int acc[4];
    logic [1:0] isel, ridx;
    logic [3:0] rd;

    tbl[0]  = '{1'b1, 2'd2, 4'b0000, 4'b0100, 1'b0, 1'b0, 8'd0, "accept_idx2"};
    tbl[1]  = '{1'b0, 2'd0, 4'b0000, 4'b0100, 1'b0, 1'b0, 8'd0, "grant_cycle2"};
    tbl[2]  = '{1'b1, 2'd1, 4'b0000, 4'b0100, 1'b0, 1'b0, 8'd0, "grant_ignores_valid"};
    tbl[3]  = '{1'b0, 2'd0, 4'b0100, 4'b0000, 1'b0, 1'b0, 8'd1, "done_idx2_gap"};
    tbl[4]  = '{1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'd1, "gap_to_idle"};
    tbl[5]  = '{1'b0, 2'd0, 4'b1111, 4'b0000, 1'b1, 1'b0, 8'd1, "idle_ignores_done"};
    tbl[6]  = '{1'b1, 2'd0, 4'b0001, 4'b0001, 1'b0, 1'b0, 8'd1, "accept_idx0_done_ignored"};
    tbl[7]  = '{1'b0, 2'd0, 4'b1110, 4'b0001, 1'b0, 1'b0, 8'd1, "other_done_ignored"};
    tbl[8]  = '{1'b0, 2'd0, 4'b0001, 4'b0000, 1'b0, 1'b0, 8'd2, "done_idx0_gap"};
    tbl[9]  = '{1'b1, 2'd3, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'd2, "gap_not_accepting"};
    tbl[10] = '{1'b1, 2'd3, 4'b0000, 4'b1000, 1'b0, 1'b0, 8'd2, "accept_idx3"};
    tbl[11] = '{1'b0, 2'd0, 4'b1000, 4'b0000, 1'b0, 1'b0, 8'd3, "done_idx3_gap"};
    tbl[12] = '{1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'd3, "idle_again"};

    rst_n = 1'b0; in_valid = 1'b0; in_idx = '0; done = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_state", 4'b0000, 1'b1, 1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkModel("after_reset");

    foreach (tbl[r]) begin
      applyStimulus(tbl[r].v, tbl[r].idx, tbl[r].d);
      checkOutput(tbl[r].name, tbl[r].eg, tbl[r].er, !tbl[r].er, tbl[r].et, tbl[r].ec);
    end

    // Timeout: idx 1 with done never asserted.
    base = m_count; glen = 0; tpulses = 0;
    applyStimulus(1'b1, 2'd1, 4'b0000);
    checkModel("timeout_accept");
    if (grant == 4'b0010) glen++;
    for (int k = 0; k < 22; k++) begin
      applyStimulus(1'b0, 2'd0, 4'b0000);
      checkModel("timeout_seq");
      if (grant == 4'b0010) glen++;
      if (timeout_err) tpulses++;
    end
    checkValue("timeout_grant_len", glen, TIMEOUT);
    checkValue("timeout_err_pulses", tpulses, 1);
    checkValue("timeout_count_kept", int'(grant_count), base);

    // Done exactly in the last allowed grant cycle.
    base = m_count; tpulses = 0;
    applyStimulus(1'b1, 2'd2, 4'b0000);
    checkModel("boundary_accept");
    for (int k = 0; k < TIMEOUT - 1; k++) begin
      applyStimulus(1'b0, 2'd0, 4'b0000);
      checkModel("boundary_seq");
    end
    checkValue("boundary_still_granted", int'(grant), 4);
    applyStimulus(1'b0, 2'd0, 4'b0100);
    checkModel("boundary_done");
    if (timeout_err) tpulses++;
    applyStimulus(1'b0, 2'd0, 4'b0000);
    checkModel("boundary_idle");
    if (timeout_err) tpulses++;
    checkValue("boundary_no_timeout", tpulses, 0);
    checkValue("boundary_count", int'(grant_count), (base + 1) % 256);

    // Done for the wrong requester must not end the grant.
    glen = 0;
    applyStimulus(1'b1, 2'd3, 4'b0000);
    checkModel("wrongdone_accept");
    if (grant == 4'b1000) glen++;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 2'd0, 4'b0001);
      checkModel("wrongdone_seq");
      if (grant == 4'b1000) glen++;
    end
    applyStimulus(1'b0, 2'd0, 4'b1000);
    checkModel("wrongdone_end");
    if (grant == 4'b1000) glen++;
    checkValue("wrongdone_grant_len", glen, 6);
    drain("wrongdone_drain");

    // Back-to-back with in_valid held high and done in the first grant cycle.
    n_acc = 0;
    for (int k = 0; k < 7; k++) begin
      isel = (n_acc == 0) ? 2'd0 : 2'd3;
      if (in_ready && n_acc < 4) begin
        acc[n_acc] = cyc;
        n_acc++;
      end
      applyStimulus(1'b1, isel, owner_mask());
      checkModel("b2b_seq");
    end
    checkValue("b2b_accepts", n_acc, 3);
    checkValue("b2b_spacing1", acc[1] - acc[0], 3);
    checkValue("b2b_spacing2", acc[2] - acc[1], 3);
    drain("b2b_drain");

    // Asynchronous reset in the second grant cycle, then a normal accept.
    applyStimulus(1'b1, 2'd2, 4'b0000);
    applyStimulus(1'b0, 2'd0, 4'b0000);
    checkModel("midgrant_cycle2");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checkOutput("midgrant_async_reset", 4'b0000, 1'b1, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    checkOutput("midgrant_held_reset", 4'b0000, 1'b1, 1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 2'd1, 4'b0000);
    checkModel("post_reset_accept");
    checkValue("post_reset_grant", int'(grant), 2);
    drain("post_reset_drain");

    // 256 done-ended grants from reset wrap the count back to zero.
    doReset();
    for (int g = 0; g < 256; g++) begin
      ridx = 2'($urandom_range(0, 3));
      applyStimulus(1'b1, ridx, 4'b0000);
      checkModel("wrap_accept");
      applyStimulus(1'b0, 2'd0, 4'(1 << ridx));
      checkModel("wrap_done");
      applyStimulus(1'b0, 2'd0, 4'b0000);
      if (g == 254) checkValue("wrap_count_255", int'(grant_count), 255);
    end
    checkValue("wrap_count_0", int'(grant_count), 0);

    // Random traffic against the model.
    for (int k = 0; k < 2000; k++) begin
      ridx = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) rd = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 9) == 0) rd = owner_mask();
      else rd = 4'b0000;
      applyStimulus(($urandom_range(0, 3) != 0), ridx, rd);
      checkModel("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/grant_decoder.md
GRANT_DECODER -- requirements
Module: grant_decoder

Interface
REQ-001 SHALL have parameter IDXW, default 2: width of the request index; N = 2**IDXW (derived, not overridable) is the number of grant lines.
REQ-002 SHALL have parameter TIMEOUT, default 16: maximum grant cycles; legal range 1..255.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  index is valid (the status output of the upstream priority encoder).
REQ-006 SHALL have port in_idx  input  IDXW  index of the winning requester.
REQ-007 SHALL have port in_ready  output  1  block can accept an index this cycle.
REQ-008 SHALL have port done  input  N  per-requester completion strobes.
REQ-009 SHALL have port grant  output  N  one-hot grant, or all zero.
REQ-010 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-011 SHALL have port timeout_err  output  1  one-cycle pulse when a grant ends without done.
REQ-012 SHALL have port grant_count  output  8  count of grants ended by done.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, GRANT, GAP; all outputs SHALL be registered or decoded from registered state only.
REQ-014 IDLE: in_ready=1, grant=0; on a rising edge with in_valid=1, in_idx SHALL be captured and the FSM SHALL enter GRANT.
REQ-015 An accepted index SHALL appear as grant = 1<<idx in the first cycle after the accepting edge (latency 1).
REQ-016 GRANT: in_ready=0; grant SHALL stay constant; changes on in_valid/in_idx SHALL be ignored.
REQ-017 GRANT: an internal grant-cycle counter SHALL be 1 in the first grant cycle and increment each further grant cycle.
REQ-018 GRANT: if done[idx]=1 at an edge, the FSM SHALL enter GAP and grant_count SHALL increment (wrap 255->0).
REQ-019 done bits other than done[idx], and any done bit outside GRANT, SHALL be ignored.
REQ-020 GRANT: if done[idx]=0 at an edge while the counter equals TIMEOUT, the FSM SHALL enter GAP with timeout_err=1 for exactly the GAP cycle; grant_count is unchanged.
REQ-021 done[idx]=1 in the TIMEOUT-th cycle SHALL count as done: no timeout_err, and grant_count increments.
REQ-022 Grant duration SHALL be at least 1 and at most TIMEOUT cycles.
REQ-023 GAP: grant=0 and in_ready=0 for exactly one cycle, then IDLE.
REQ-024 Minimum spacing between accepting edges SHALL be 3 cycles when done arrives in the first grant cycle.
REQ-025 grant SHALL never have more than one bit set, including across state transitions.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, grant=0, busy=0, timeout_err=0, grant_count=0, counter=0, captured index=0; in_ready SHALL be 1.
REQ-027 Reset asserted during GRANT SHALL drop grant in the same cycle; no timeout_err and no grant_count update.
REQ-028 After rst_n deasserts, the first edge with in_valid=1 SHALL be accepted normally.

Verification
REQ-029 Basic grant: in_valid=1, in_idx=2 for one cycle; done=4'b0100 in the 3rd grant cycle -> grant=4'b0100 for 3 cycles, one GAP cycle, grant_count=1, timeout_err never high.
REQ-030 Timeout: TIMEOUT=16, in_idx=1, done held 0 -> grant=4'b0010 for exactly 16 cycles, then timeout_err=1 for one cycle, grant_count unchanged.
REQ-031 Boundary: done[idx] arrives in grant cycle 16 with TIMEOUT=16 -> no timeout_err, grant_count increments.
REQ-032 Wrong done: in_idx=3, done=4'b0001 for 5 cycles, then done=4'b1000 -> grant=4'b1000 held 6 cycles; only the done[3] cycle ends the grant.
REQ-033 Back-to-back: in_valid held 1, in_idx 0 then 3, done strobed on the first grant cycle -> accepting edges 3 cycles apart, grants 4'b0001 then 4'b1000, in_ready low during GRANT and GAP.
REQ-034 Reset mid-grant and counter wrap: rst_n pulsed low in grant cycle 2 -> all outputs return to reset values asynchronously; separately, 256 done-ended grants -> grant_count=0.
